// File: rtl/password_lock_fsm.sv
// Keypad door-lock controller: digit entry, registered code compare,
// timed access/lockout, failure counting and in-field code reprogramming.
module password_lock_fsm #(
    parameter int DIGITS                              = 8,
    parameter int DIGIT_W                             = 4,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 'h12345678,
    parameter int MAX_TRIES                           = 3,
    parameter int ACCESS_CYCLES                       = 500,
    parameter int LOCKOUT_CYCLES                      = 1000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             key_valid,
    input  logic [DIGIT_W-1:0]               key_data,
    input  logic                             key_enter,
    input  logic                             key_clear,
    input  logic                             prog_req,
    output logic                             access,
    output logic                             alarm,
    output logic                             prog_active,
    output logic                             prog_done,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt
);

    localparam int CW   = DIGITS * DIGIT_W;
    localparam int NW   = $clog2(DIGITS + 2);
    localparam int FW   = $clog2(MAX_TRIES + 1);
    localparam int MAXC = (ACCESS_CYCLES > LOCKOUT_CYCLES) ?
                          ACCESS_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(MAXC) + 1;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        GRANT,
        LOCKOUT,
        PROG
    } state_t;

    state_t          state;
    logic [CW-1:0]   buffer;
    logic [CW-1:0]   code;
    logic [NW-1:0]   cnt;
    logic [TW-1:0]   timer;

    logic [CW-1:0]   shifted;
    logic [NW-1:0]   cnt_inc;
    logic [FW:0]     fail_inc;
    logic            full;
    logic            match;

    assign shifted  = {buffer[CW-DIGIT_W-1:0], key_data};
    assign cnt_inc  = (cnt == NW'(DIGITS + 1)) ? cnt : cnt + NW'(1);
    assign fail_inc = {1'b0, fail_cnt} + (FW+1)'(1);
    assign full     = (cnt == NW'(DIGITS));
    assign match    = full && (buffer == code);

    // Outputs are decoded from the registered state, so they trail it by
    // one clock and never see a combinational path from the keypad.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            buffer      <= '0;
            cnt         <= '0;
            code        <= DEFAULT_CODE;
            timer       <= '0;
            fail_cnt    <= '0;
            access      <= 1'b0;
            alarm       <= 1'b0;
            prog_active <= 1'b0;
            prog_done   <= 1'b0;
        end else begin
            access      <= (state == GRANT);
            alarm       <= (state == LOCKOUT);
            prog_active <= (state == PROG);
            prog_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (key_valid) begin
                        buffer <= shifted;
                        cnt    <= NW'(1);
                        state  <= ENTRY;
                    end
                end
                ENTRY: begin
                    if (key_clear) begin
                        buffer <= '0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else if (key_enter) begin
                        state  <= CHECK;
                    end else if (key_valid) begin
                        buffer <= shifted;
                        cnt    <= cnt_inc;
                    end
                end
                CHECK: begin
                    buffer <= '0;
                    cnt    <= '0;
                    if (match) begin
                        fail_cnt <= '0;
                        timer    <= TW'(ACCESS_CYCLES - 1);
                        state    <= GRANT;
                    end else if (fail_inc == (FW+1)'(MAX_TRIES)) begin
                        fail_cnt <= FW'(MAX_TRIES);
                        timer    <= TW'(LOCKOUT_CYCLES - 1);
                        state    <= LOCKOUT;
                    end else begin
                        fail_cnt <= fail_inc[FW-1:0];
                        state    <= IDLE;
                    end
                end
                GRANT: begin
                    if (prog_req) begin
                        state <= PROG;
                    end else if (timer == '0) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        fail_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                PROG: begin
                    if (key_clear) begin
                        buffer <= '0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else if (key_enter) begin
                        if (full) begin
                            code      <= buffer;
                            prog_done <= 1'b1;
                        end
                        buffer <= '0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else if (key_valid) begin
                        buffer <= shifted;
                        cnt    <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_password_lock_fsm.sv
// Directed bench for password_lock_fsm: table of code submissions
// plus hand sequences for lockout, reprogramming, reset and priority.
module tb_password_lock_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_data;
    logic       key_enter;
    logic       key_clear;
    logic       prog_req;
    logic       access;
    logic       alarm;
    logic       prog_active;
    logic       prog_done;
    logic [1:0] fail_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    password_lock_fsm #(
        .ACCESS_CYCLES (8),
        .LOCKOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .key_enter  (key_enter),
        .key_clear  (key_clear),
        .prog_req   (prog_req),
        .access     (access),
        .alarm      (alarm),
        .prog_active(prog_active),
        .prog_done  (prog_done),
        .fail_cnt   (fail_cnt)
    );

    typedef struct {
        logic [35:0] code;
        int          n;
        bit          grant;
        int          fail;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_data  = d;
        step();
        key_valid = 1'b0;
    endtask

    task automatic submit(input logic [35:0] v, input int n);
        logic [35:0] t;
        for (int i = 0; i < n; i++) begin
            t = v >> (4 * (n - 1 - i));
            press(t[3:0]);
        end
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
    endtask

    // Call right after the enter edge; checks latency, fail count and,
    // for a grant, the exact length of the access pulse.
    task automatic result(input string name, input bit grant,
                          input int fail);
        int len;
        step();
        chk({name, "_fail"}, 32'(fail_cnt), fail);
        chk({name, "_early"}, 32'(access), 0);
        step();
        chk({name, "_access"}, 32'(access), 32'(grant));
        chk({name, "_alarm"}, 32'(alarm), 0);
        if (grant) begin
            len = 1;
            for (int i = 0; i < 30; i++) begin
                step();
                if (!access) break;
                len++;
            end
            chk({name, "_len"}, len, 8);
            chk({name, "_fail_after"}, 32'(fail_cnt), 0);
        end
    endtask

    task automatic grant_hold(input logic [35:0] v);
        submit(v, 8);
        step();
        step();
        chk("grant_hold", 32'(access), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        vecs[0] = '{36'h12345678,  8, 1, 0};
        vecs[1] = '{36'h1234567,   7, 0, 1};
        vecs[2] = '{36'h123456789, 9, 0, 2};
        vecs[3] = '{36'h12345678,  8, 1, 0};
        vecs[4] = '{36'h14343542,  8, 0, 1};
        vecs[5] = '{36'h12345678,  8, 1, 0};
        vecs[6] = '{36'h1242adcb,  8, 0, 1};
        vecs[7] = '{36'h1234abcd,  8, 0, 2};

        reset     = 1'b0;
        key_valid = 1'b0;
        key_data  = '0;
        key_enter = 1'b0;
        key_clear = 1'b0;
        prog_req  = 1'b0;
        repeat (3) step();
        chk("rst_access", 32'(access), 0);
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_prog_active", 32'(prog_active), 0);
        chk("rst_prog_done", 32'(prog_done), 0);
        chk("rst_fail", 32'(fail_cnt), 0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            submit(vecs[i].code, vecs[i].n);
            result($sformatf("v%0d", i), vecs[i].grant, vecs[i].fail);
        end

        // Third consecutive failure: lockout, keys ignored meanwhile
        submit(36'h11111111, 8);
        step();
        chk("lock_fail", 32'(fail_cnt), 3);
        chk("lock_early", 32'(alarm), 0);
        step();
        chk("lock_alarm", 32'(alarm), 1);
        chk("lock_access", 32'(access), 0);
        len = 1;
        for (int i = 0; i < 40; i++) begin
            key_valid = 1'b1;
            key_data  = 4'(i + 1);
            key_enter = (i % 3 == 2);
            step();
            if (!alarm) break;
            len++;
        end
        key_valid = 1'b0;
        key_enter = 1'b0;
        chk("lock_len", len, 16);
        chk("lock_fail_after", 32'(fail_cnt), 0);
        key_clear = 1'b1;
        step();
        key_clear = 1'b0;
        submit(36'h12345678, 8);
        result("post_lock", 1, 0);

        // Reprogram to 1234abcd
        grant_hold(36'h12345678);
        prog_req = 1'b1;
        step();
        prog_req = 1'b0;
        press(4'h1);
        chk("prog_active", 32'(prog_active), 1);
        for (int i = 2; i <= 8; i++) begin
            logic [31:0] nc;
            nc = 32'h1234abcd;
            press(nc[4*(8-i) +: 4]);
        end
        chk("prog_done_early", 32'(prog_done), 0);
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        chk("prog_done", 32'(prog_done), 1);
        chk("prog_access", 32'(access), 0);
        step();
        chk("prog_done_pulse", 32'(prog_done), 0);
        submit(36'h12345678, 8);
        result("old_code", 0, 1);
        submit(36'h1234abcd, 8);
        result("new_code", 1, 0);

        // Short PROG entry keeps the old code
        grant_hold(36'h1234abcd);
        prog_req = 1'b1;
        step();
        prog_req = 1'b0;
        for (int i = 0; i < 5; i++) press(4'h9);
        key_enter = 1'b1;
        step();
        key_enter = 1'b0;
        chk("short_prog_done", 32'(prog_done), 0);
        step();
        submit(36'h1234abcd, 8);
        result("short_keep", 1, 0);

        // Cleared PROG entry keeps the old code
        grant_hold(36'h1234abcd);
        prog_req = 1'b1;
        step();
        prog_req = 1'b0;
        for (int i = 0; i < 8; i++) press(4'h5);
        key_clear = 1'b1;
        step();
        key_clear = 1'b0;
        chk("clr_prog_done", 32'(prog_done), 0);
        step();
        submit(36'h55555555, 8);
        result("clr_reject", 0, 1);
        submit(36'h1234abcd, 8);
        result("clr_keep", 1, 0);

        // Asynchronous reset mid-lockout restores the default code
        submit(36'h0, 8);
        result("rl1", 0, 1);
        submit(36'h0, 8);
        result("rl2", 0, 2);
        submit(36'h0, 8);
        step();
        step();
        chk("rl_alarm", 32'(alarm), 1);
        repeat (3) step();
        #2;
        reset = 1'b0;
        #1;
        chk("rl_alarm_drop", 32'(alarm), 0);
        chk("rl_fail", 32'(fail_cnt), 0);
        step();
        reset = 1'b1;
        step();
        submit(36'h12345678, 8);
        result("rl_default", 1, 0);

        // Digit arriving with enter is discarded
        for (int i = 1; i <= 7; i++) press(4'(i));
        key_valid = 1'b1;
        key_data  = 4'h8;
        key_enter = 1'b1;
        step();
        key_valid = 1'b0;
        key_enter = 1'b0;
        result("prio", 0, 1);
        submit(36'h12345678, 8);
        result("prio_ok", 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
